// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the SDF FFT stage controllers and the twiddle datapath.
package fft_ctrl_pkg;

    // Control-unit sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } cu_state_e;

    // Trivial-twiddle select codes understood by the twiddle multiplier.
    localparam logic [1:0] TW_PASS  = 2'b00;
    localparam logic [1:0] TW_NEG_J = 2'b01;

endpackage

// File: rtl/sdf_phase_cnt.sv
// Frame sample counter for one SDF stage, plus the phase decodes derived
// from it: feedback-mux bit, group bit and end-of-phase strobes.
module sdf_phase_cnt #(
    parameter int SPAN      = 4,
    parameter int FRAME_LEN = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic                         adv,
    output logic [$clog2(FRAME_LEN)-1:0] cnt,
    output logic                         mux_bit,
    output logic                         grp_bit,
    output logic                         grp_last,
    output logic                         fill_last,
    output logic                         frame_last
);

    // SB is the counter bit that toggles between fill and butterfly halves.
    localparam int SB = $clog2(SPAN);
    localparam int CW = $clog2(FRAME_LEN);

    // Low bits of cnt index a sample inside one 2*SPAN group.
    localparam logic [SB:0]   GRP_END   = {(SB + 1){1'b1}};
    localparam logic [SB:0]   FILL_END  = GRP_END >> 1;
    localparam logic [CW-1:0] FRAME_END = CW'(FRAME_LEN - 1);

    logic [SB:0] lo;

    assign lo         = cnt[SB:0];
    assign mux_bit    = cnt[SB];
    assign grp_last   = (lo == GRP_END);
    assign fill_last  = (lo == FILL_END);
    assign frame_last = (cnt == FRAME_END);

    // A frame of exactly 2*SPAN samples has no group bit; it is then always 0.
    if (SB + 1 < CW) begin : g_grp
        assign grp_bit = cnt[SB + 1];
    end else begin : g_no_grp
        assign grp_bit = 1'b0;
    end

    // Sample counter: cleared on a frame start, wraps at the frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (adv) begin
            cnt <= frame_last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/cu_sdf_stage.sv
// Control unit for one single-delay-feedback FFT stage: sequences a frame
// from alert_in, drives the feedback mux, butterfly enable and trivial
// twiddle select, forwards the start pulse and flags overruns.
module cu_sdf_stage
    import fft_ctrl_pkg::*;
#(
    parameter int SPAN      = 4,
    parameter int FRAME_LEN = 16,
    parameter int TW_MODE   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alert_in,
    output logic       mux_sel,
    output logic       bf_en,
    output logic       tw_en,
    output logic [1:0] tw_sel,
    output logic       alert_out,
    output logic       busy,
    output logic       overrun
);

    localparam int              CW        = $clog2(FRAME_LEN);
    localparam int              DW        = $clog2(SPAN) + 1;
    localparam logic [DW-1:0]   DRAIN_END = DW'(SPAN - 1);
    localparam logic [CW-1:0]   ALERT_CNT = CW'(SPAN);

    cu_state_e     state;
    logic [DW-1:0] dcnt;
    logic          dl_full;
    logic          grp;

    logic [CW-1:0] cnt;
    logic          mux_bit;
    logic          grp_bit;
    logic          grp_last;
    logic          fill_last;
    logic          frame_last;
    logic          in_run;
    logic          in_drain;
    logic          cnt_load;

    assign in_run   = (state == RUN);
    assign in_drain = (state == DRAIN);
    // A start outside RUN always begins at sample 0; inside RUN the counter
    // wraps to 0 by itself at the frame end.
    assign cnt_load = alert_in & ~in_run;

    sdf_phase_cnt #(
        .SPAN      (SPAN),
        .FRAME_LEN (FRAME_LEN)
    ) u_phase_cnt (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .adv        (in_run),
        .cnt        (cnt),
        .mux_bit    (mux_bit),
        .grp_bit    (grp_bit),
        .grp_last   (grp_last),
        .fill_last  (fill_last),
        .frame_last (frame_last)
    );

    // Sequencing FSM with drain counter and sticky overrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            dcnt    <= '0;
            overrun <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (alert_in) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (frame_last) begin
                        // A start on the last sample is a legal back-to-back frame.
                        if (!alert_in) begin
                            state <= DRAIN;
                            dcnt  <= '0;
                        end
                    end else if (alert_in) begin
                        overrun <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (alert_in) begin
                        state <= RUN;
                    end else if (dcnt == DRAIN_END) begin
                        state <= IDLE;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Delay-line tracker: full after each butterfly half, empty once the
    // following mux_sel=0 stretch has shifted SPAN differences out. A restart
    // during DRAIN keeps mux_sel low, so that stretch runs on into the new fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_full <= 1'b0;
            grp     <= 1'b0;
        end else if (in_run && grp_last) begin
            dl_full <= 1'b1;
            grp     <= grp_bit;
        end else if ((in_run && fill_last) || (in_drain && dcnt == DRAIN_END)) begin
            dl_full <= 1'b0;
        end
    end

    assign mux_sel   = in_run & mux_bit;
    assign bf_en     = mux_sel;
    assign tw_en     = dl_full & ~mux_sel;
    assign tw_sel    = ((TW_MODE == 1) && tw_en && grp) ? TW_NEG_J : TW_PASS;
    assign alert_out = in_run & (cnt == ALERT_CNT);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_cu_sdf_stage.sv
// Directed bench for cu_sdf_stage: a SPAN=4/FRAME_LEN=16/TW_MODE=1 instance
// and a SPAN=1/FRAME_LEN=4/TW_MODE=0 instance, checked cycle by cycle
// against hand-derived per-cycle masks.
module tb_cu_sdf_stage;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A: SPAN=4, FRAME_LEN=16, TW_MODE=1 ----------------
    logic       alert_a;
    logic       mux_a, bf_a, twen_a, aout_a, busy_a, ovr_a;
    logic [1:0] twsel_a;

    cu_sdf_stage #(
        .SPAN      (4),
        .FRAME_LEN (16),
        .TW_MODE   (1)
    ) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .alert_in  (alert_a),
        .mux_sel   (mux_a),
        .bf_en     (bf_a),
        .tw_en     (twen_a),
        .tw_sel    (twsel_a),
        .alert_out (aout_a),
        .busy      (busy_a),
        .overrun   (ovr_a)
    );

    // ---------------- DUT B: SPAN=1, FRAME_LEN=4, TW_MODE=0 ----------------
    logic       alert_b;
    logic       mux_b, bf_b, twen_b, aout_b, busy_b, ovr_b;
    logic [1:0] twsel_b;

    cu_sdf_stage #(
        .SPAN      (1),
        .FRAME_LEN (4),
        .TW_MODE   (0)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .alert_in  (alert_b),
        .mux_sel   (mux_b),
        .bf_en     (bf_b),
        .tw_en     (twen_b),
        .tw_sel    (twsel_b),
        .alert_out (aout_b),
        .busy      (busy_b),
        .overrun   (ovr_b)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks;
    int n_errors;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bit mask with cycles lo..hi set.
    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] r;
        r = '0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    // ---------------- driver / per-cycle checker ----------------
    // Called at the start of cycle 0; for every cycle c it checks the DUT
    // outputs against the masks, drives alert_in for cycle c, then advances.
    task automatic run_scen(input string name, input int which, input int ncyc,
                            input logic [63:0] al, input logic [63:0] mux,
                            input logic [63:0] aout, input logic [63:0] bsy,
                            input logic [63:0] twen, input logic [63:0] twsel,
                            input logic [63:0] ovr);
        logic [1:0] exp_sel;
        for (int c = 0; c < ncyc; c++) begin
            exp_sel = twsel[c] ? 2'b01 : 2'b00;
            if (which == 0) begin
                check($sformatf("%s mux_sel c%0d", name, c),   {7'd0, mux_a},  {7'd0, mux[c]});
                check($sformatf("%s bf_en c%0d", name, c),     {7'd0, bf_a},   {7'd0, mux[c]});
                check($sformatf("%s alert_out c%0d", name, c), {7'd0, aout_a}, {7'd0, aout[c]});
                check($sformatf("%s busy c%0d", name, c),      {7'd0, busy_a}, {7'd0, bsy[c]});
                check($sformatf("%s tw_en c%0d", name, c),     {7'd0, twen_a}, {7'd0, twen[c]});
                check($sformatf("%s tw_sel c%0d", name, c),    {6'd0, twsel_a}, {6'd0, exp_sel});
                check($sformatf("%s overrun c%0d", name, c),   {7'd0, ovr_a},  {7'd0, ovr[c]});
                alert_a = al[c];
            end else begin
                check($sformatf("%s mux_sel c%0d", name, c),   {7'd0, mux_b},  {7'd0, mux[c]});
                check($sformatf("%s bf_en c%0d", name, c),     {7'd0, bf_b},   {7'd0, mux[c]});
                check($sformatf("%s alert_out c%0d", name, c), {7'd0, aout_b}, {7'd0, aout[c]});
                check($sformatf("%s busy c%0d", name, c),      {7'd0, busy_b}, {7'd0, bsy[c]});
                check($sformatf("%s tw_en c%0d", name, c),     {7'd0, twen_b}, {7'd0, twen[c]});
                check($sformatf("%s tw_sel c%0d", name, c),    {6'd0, twsel_b}, {6'd0, exp_sel});
                check($sformatf("%s overrun c%0d", name, c),   {7'd0, ovr_b},  {7'd0, ovr[c]});
                alert_b = al[c];
            end
            @(posedge clk);
            #1;
        end
        alert_a = 1'b0;
        alert_b = 1'b0;
    endtask

    task automatic check_zero_a(input string name);
        check($sformatf("%s mux_sel", name),   {7'd0, mux_a},   8'd0);
        check($sformatf("%s bf_en", name),     {7'd0, bf_a},    8'd0);
        check($sformatf("%s tw_en", name),     {7'd0, twen_a},  8'd0);
        check($sformatf("%s tw_sel", name),    {6'd0, twsel_a}, 8'd0);
        check($sformatf("%s alert_out", name), {7'd0, aout_a},  8'd0);
        check($sformatf("%s busy", name),      {7'd0, busy_a},  8'd0);
        check($sformatf("%s overrun", name),   {7'd0, ovr_a},   8'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        alert_a  = 1'b0;
        alert_b  = 1'b0;
        rst      = 1'b1;

        #1;
        check_zero_a("rst_async");
        repeat (2) @(posedge clk);
        #1;
        check_zero_a("rst_held");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single frame: fill/butterfly halves, alert_out at cycle 5, drain 17-20.
        run_scen("single", 0, 23, rng(0, 0),
                 rng(5, 8) | rng(13, 16),
                 rng(5, 5),
                 rng(1, 20),
                 rng(9, 12) | rng(17, 20),
                 rng(17, 20),
                 64'd0);

        // Back-to-back frames: no drain between, drain only after the second.
        run_scen("b2b", 0, 38, rng(0, 0) | rng(16, 16),
                 rng(5, 8) | rng(13, 16) | rng(21, 24) | rng(29, 32),
                 rng(5, 5) | rng(21, 21),
                 rng(1, 36),
                 rng(9, 12) | rng(17, 20) | rng(25, 28) | rng(33, 36),
                 rng(17, 20) | rng(33, 36),
                 64'd0);

        // Restart in the second drain cycle: new frame cnt=0 at cycle 19.
        run_scen("restart", 0, 40, rng(0, 0) | rng(18, 18),
                 rng(5, 8) | rng(13, 16) | rng(23, 26) | rng(31, 34),
                 rng(5, 5) | rng(23, 23),
                 rng(1, 38),
                 rng(9, 12) | rng(17, 22) | rng(27, 30) | rng(35, 38),
                 rng(17, 22) | rng(35, 38),
                 64'd0);

        // Overrun: second start mid-frame sets the sticky flag from cycle 8.
        run_scen("overrun", 0, 23, rng(0, 0) | rng(7, 7),
                 rng(5, 8) | rng(13, 16),
                 rng(5, 5),
                 rng(1, 20),
                 rng(9, 12) | rng(17, 20),
                 rng(17, 20),
                 rng(8, 22));

        // Frame interrupted by reset in cycle 10; overrun still set before it.
        run_scen("abort", 0, 10, rng(0, 0),
                 rng(5, 8),
                 rng(5, 5),
                 rng(1, 9),
                 rng(9, 9),
                 64'd0,
                 rng(0, 9));
        #2;
        rst = 1'b1;
        #1;
        check_zero_a("rst_midrun");
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Clean restart after the reset.
        run_scen("post_rst", 0, 23, rng(0, 0),
                 rng(5, 8) | rng(13, 16),
                 rng(5, 5),
                 rng(1, 20),
                 rng(9, 12) | rng(17, 20),
                 rng(17, 20),
                 64'd0);

        // SPAN=1, FRAME_LEN=4, TW_MODE=0: tw_sel never leaves 00.
        run_scen("span1", 1, 8, rng(0, 0),
                 rng(2, 2) | rng(4, 4),
                 rng(2, 2),
                 rng(1, 5),
                 rng(3, 3) | rng(5, 5),
                 64'd0,
                 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
